fft_input_framer: RTL and testbench
===================================

# fft_input_framer

Front-end sequencer feeding the pipelined FFT's load port. Accepts a complex sample stream over a valid/ready handshake, tags each sample with its (bit-reversed) write address, drives the FFT's `load_data`/`Re_i`/`Im_i`/`invert_addr` inputs, and pulses `start_flag` once a full N-point frame has been written. Enforces a programmable inter-frame gap so the first FFT stage is never overwritten while it is still reading a frame.

## Interface
- `bit_width`, 24, sample width (signed, two's complement), matches FFT data width
- `N`, 16, FFT points per frame
- `SIZE`, 4, log2(N); address width
- `gap_cycles`, 32, cycles `s_ready` stays low after each `start_flag`; legal range is 1 or more

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous active-low reset
- `en_i`  in  1  framer enable; sampled only in IDLE and at frame boundaries
- `s_valid`  in  1  input sample valid
- `s_re`  in  bit_width  input real part
- `s_im`  in  bit_width  input imaginary part
- `s_last`  in  1  marks the final sample of a frame, as asserted by the source
- `s_ready`  out  1  framer accepts a sample this cycle
- `load_data`  out  1  to FFT `load_data`: write strobe
- `Re_i`  out  bit_width  to FFT `Re_i`
- `Im_i`  out  bit_width  to FFT `Im_i`
- `invert_addr`  out  SIZE  to FFT `invert_addr`: write address
- `start_flag`  out  1  to FFT `start_flag`: 1-cycle pulse, frame complete
- `frame_err`  out  1  sticky: `s_last` was misplaced
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, LOAD, START and GAP.
- IDLE: `s_ready`=0. Moves to LOAD when `en_i`=1.
- LOAD: `s_ready`=1.
  - Each handshake (`s_valid & s_ready`) writes one sample and increments `idx` (SIZE bits, starting at 0).
  - On the handshake with `idx`=N-1, the FSM moves to START.
- START: one cycle long. Asserts `start_flag`, then moves to GAP.
- GAP: `s_ready`=0 for `gap_cycles` cycles. Then the FSM goes to LOAD if `en_i`=1, otherwise to IDLE.
- Deasserting `en_i` mid-frame has no effect until the frame completes.
- Address: `invert_addr` = bitrev(`idx`) over SIZE bits. For N=16: idx 1→8, idx 3→12, idx 15→15.
- Framing check:
  - `s_last`=1 with `idx`≠N-1 sets `frame_err`.
  - `s_last`=0 with `idx`=N-1 also sets `frame_err`.
  - In both cases the frame still completes on the idx count. `s_last` never truncates or extends a frame.
  - `frame_err` clears only on reset.
- Data passes through unchanged; no scaling, no width change.

## Timing
- All outputs are registered.
- Reset values: `s_ready`=0, `load_data`=0, `Re_i`=0, `Im_i`=0, `invert_addr`=0, `start_flag`=0, `frame_err`=0, `busy`=0. State = IDLE, `idx`=0, gap counter = 0.
- A handshake in cycle t produces `load_data`=1 with that sample's data and address in cycle t+1. Otherwise `load_data`=0. Data/address outputs hold their last values.
- The last handshake at cycle t gives its `load_data` at t+1 and `start_flag` at t+1. The FFT samples start with the last write complete.
- `s_ready` falls in the cycle after the last handshake. It rises no earlier than `gap_cycles`+1 cycles after `start_flag`.
- `s_valid` low in LOAD simply stalls; `idx` holds. There is no timeout.
- Reset asserted mid-frame: the partial frame is discarded, no `start_flag` is issued, and all outputs return to their reset values immediately (asynchronous).
- `idx` wraps N-1→0 at frame end. `gap_cycles`=1 gives back-to-back frames separated by 2 non-ready cycles (START + 1 GAP).

## Configuration
- `FFT_FRAMER_BITREV_EN` defined: `invert_addr` = bitrev(`idx`). This is the default build for the FFT pipeline.
- `FFT_FRAMER_BITREV_EN` undefined: `invert_addr` = `idx` (natural order), for FFT variants that reorder internally. All timing is identical in both builds.

## Structure
- Shared package `fft_pkg`: FSM state enum, `bitrev` function parameterised on SIZE, and the default `bit_width`/`N`/`SIZE` constants shared with the FFT stages.
- One sub-module is natural: `gap_timer`, a loadable down-counter with a `done` flag, reusable by the FFT output side.

## Test plan
- Reset, `en_i`=1, stream samples 0..15 (re=k, im=-k) with `s_valid` held high:
  - 16 `load_data` pulses; the pulse for k=1 carries `invert_addr`=8 and k=3 carries 12.
  - `start_flag` is coincident with the 16th `load_data`.
  - `s_ready` stays low for `gap_cycles`+1 cycles.
- Random `s_valid` gaps (≈50%) → identical address/data sequence; exactly one `start_flag` per 16 handshakes.
- `s_last` asserted on sample 9 → `frame_err`=1; the frame still ends at sample 15; `frame_err` stays set through later clean frames.
- Reset pulsed after 7 samples, then a fresh 16-sample frame → no `start_flag` for the partial frame; the new frame starts at `invert_addr`=0.
- `en_i` dropped after sample 5 → frame completes with `start_flag`, FSM returns to IDLE with `busy`=0 after the gap, and `s_ready` stays 0.
- Build without `FFT_FRAMER_BITREV_EN` → `invert_addr` sequence is 0,1,2..15 with cycle timing unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default data/frame sizes, framer FSM states and the
// bit-reverse helper used for the FFT load-port addressing.
package fft_pkg;

  localparam int FFT_BIT_WIDTH = 24;
  localparam int FFT_N         = 16;
  localparam int FFT_SIZE      = 4;
  localparam int MAX_SIZE      = 16;  // widest address the helper handles

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_GAP
  } framer_state_e;

  // Reverse the low `size` bits of v; callers cast the result to their width.
  function automatic logic [MAX_SIZE-1:0] bitrev(input logic [MAX_SIZE-1:0] v,
                                                 input int size);
    logic [MAX_SIZE-1:0] full;
    full = {<<{v}};
    return full >> (MAX_SIZE - size);
  endfunction

endpackage

// File: rtl/fft_input_framer_gap_timer.sv
// gap_timer: loadable down-counter; done_o is high once the count reaches 0.
// Loading V gives V+1 cycles including the done cycle.
module gap_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt_q <= '0;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: collects an N-sample complex frame over valid/ready, writes
// it into the FFT load port and pulses start_flag when the frame is complete,
// then holds off input for gap_cycles so the first FFT stage is not overrun.
// Build option FFT_FRAMER_BITREV_EN: when defined the write address is the
// bit-reversed sample index, otherwise the natural index.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int bit_width  = FFT_BIT_WIDTH,
  parameter int N          = FFT_N,
  parameter int SIZE       = FFT_SIZE,
  parameter int gap_cycles = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 s_valid,
  input  logic [bit_width-1:0] s_re,
  input  logic [bit_width-1:0] s_im,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 load_data,
  output logic [bit_width-1:0] Re_i,
  output logic [bit_width-1:0] Im_i,
  output logic [SIZE-1:0]      invert_addr,
  output logic                 start_flag,
  output logic                 frame_err,
  output logic                 busy
);

  framer_state_e        state_q, state_d;
  logic [SIZE-1:0]      idx_q;
  logic                 s_ready_q, load_q, start_q, err_q, busy_q;
  logic [bit_width-1:0] re_q, im_q;
  logic [SIZE-1:0]      addr_q, addr_w;
  logic                 hs, last_idx, gap_done;

  assign hs       = s_valid & s_ready_q;
  assign last_idx = (idx_q == SIZE'(N - 1));

`ifdef FFT_FRAMER_BITREV_EN
  assign addr_w = SIZE'(bitrev(MAX_SIZE'(idx_q), SIZE));
`else
  assign addr_w = idx_q;
`endif

  // Gap length is counted from the START cycle; loading gap_cycles-1 yields
  // exactly gap_cycles GAP cycles.
  gap_timer #(.W(32)) u_gap (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_q == ST_START),
    .load_val_i (32'(gap_cycles - 1)),
    .done_o     (gap_done)
  );

  // Next-state logic; en_i only matters in IDLE and when the gap expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en_i) state_d = ST_LOAD;
      ST_LOAD:  if (hs && last_idx) state_d = ST_START;
      ST_START: state_d = ST_GAP;
      ST_GAP:   if (gap_done) state_d = en_i ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, index and registered control outputs (decoded from next state so
  // they line up with the state they describe).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == ST_LOAD);
      busy_q    <= (state_d != ST_IDLE);
      start_q   <= hs && last_idx;
      if (hs) begin
        idx_q <= idx_q + SIZE'(1);
        // s_last only flags misframing; the frame length is fixed by idx.
        if (s_last != last_idx) err_q <= 1'b1;
      end
    end
  end

  // Write port: strobe for one cycle per handshake, data/address hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= 1'b0;
      re_q   <= '0;
      im_q   <= '0;
      addr_q <= '0;
    end else begin
      load_q <= hs;
      if (hs) begin
        re_q   <= s_re;
        im_q   <= s_im;
        addr_q <= addr_w;
      end
    end
  end

  assign s_ready     = s_ready_q;
  assign load_data   = load_q;
  assign Re_i        = re_q;
  assign Im_i        = im_q;
  assign invert_addr = addr_q;
  assign start_flag  = start_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fft_input_framer.sv
// Bench for fft_input_framer: stimulus pushes expected load-port writes into a
// scoreboard queue, a negedge monitor pops and compares every load_data pulse.
module tb_fft_input_framer;

  localparam int BW  = 24;
  localparam int NP  = 16;
  localparam int SZ  = 4;
  localparam int GAP = 3;

`ifdef FFT_FRAMER_BITREV_EN
  localparam logic [SZ-1:0] BREV [NP] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                          4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en_i = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [BW-1:0] s_re = '0;
  logic [BW-1:0] s_im = '0;
  logic          s_ready, load_data, start_flag, frame_err, busy;
  logic [BW-1:0] Re_i, Im_i;
  logic [SZ-1:0] invert_addr;

  always #5 clk = ~clk;

  fft_input_framer #(.bit_width(BW), .N(NP), .SIZE(SZ), .gap_cycles(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .s_valid(s_valid), .s_re(s_re),
    .s_im(s_im), .s_last(s_last), .s_ready(s_ready), .load_data(load_data),
    .Re_i(Re_i), .Im_i(Im_i), .invert_addr(invert_addr), .start_flag(start_flag),
    .frame_err(frame_err), .busy(busy)
  );

  typedef struct packed {
    logic [BW-1:0] re;
    logic [BW-1:0] im;
    logic [SZ-1:0] addr;
    logic          start;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int starts_seen = 0;
  int starts_exp = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [SZ-1:0] exp_addr(input int k);
`ifdef FFT_FRAMER_BITREV_EN
    return BREV[k];
`else
    return SZ'(k);
`endif
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_flag) starts_seen++;
      if (load_data) begin
        if (sb.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("load_re", Re_i, e.re);
          chk("load_im", Im_i, e.im);
          chk("load_addr", invert_addr, e.addr);
          chk("load_start", start_flag, e.start);
        end
      end else begin
        chk("start_without_load", start_flag, 0);
      end
    end
  end

  // Offer sample k after `idle` empty cycles; call and return at a negedge.
  task automatic send(input int k, input bit last, input int idle);
    int n;
    repeat (idle) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_re    = BW'(k);
    s_im    = BW'(-k);
    s_last  = last;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("ready_timeout", 0, 1);
    end else begin
      sb.push_back('{re: BW'(k), im: BW'(-k), addr: exp_addr(k), start: (k == NP-1)});
      if (k == NP-1) starts_exp++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic frame(input bit gappy, input bit err9);
    for (int k = 0; k < NP; k++)
      send(k, (k == NP-1) || (err9 && k == 9), gappy ? int'($urandom_range(0, 1)) : 0);
  endtask

  task automatic expect_outputs_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_load_data"}, load_data, 0);
    chk({tag, "_re"}, Re_i, 0);
    chk({tag, "_im"}, Im_i, 0);
    chk({tag, "_addr"}, invert_addr, 0);
    chk({tag, "_start"}, start_flag, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1 expect_outputs_reset("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", s_ready, 0);
    en_i = 1'b1;
    @(negedge clk);
    chk("load_busy", busy, 1);
    chk("load_ready", s_ready, 1);

    // Frame 1: back-to-back samples, then measure the non-ready window.
    frame(1'b0, 1'b0);
    n = 0;
    while (!s_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("gap_len", n, GAP + 1);
    chk("clean_frame_err", frame_err, 0);

    // Frame 2: random valid bubbles.
    frame(1'b1, 1'b0);

    // Partial frame aborted by reset.
    for (int k = 0; k < 7; k++) send(k, 1'b0, 0);
    @(negedge clk);
    chk("partial_drained", sb.size(), 0);
    rst_n = 1'b0;
    #1 expect_outputs_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    frame(1'b0, 1'b0);

    // Misplaced s_last on sample 9; frame still ends on count.
    frame(1'b0, 1'b1);
    chk("err_set", frame_err, 1);
    frame(1'b1, 1'b0);
    chk("err_sticky", frame_err, 1);

    // en_i dropped mid-frame: frame finishes, then the FSM parks in IDLE.
    for (int k = 0; k < 6; k++) send(k, 1'b0, 0);
    en_i = 1'b0;
    @(negedge clk);
    chk("en_drop_busy", busy, 1);
    for (int k = 6; k < NP; k++) send(k, k == NP-1, 0);
    repeat (GAP + 2) @(negedge clk);
    chk("idle_after_gap_busy", busy, 0);
    chk("idle_after_gap_ready", s_ready, 0);
    repeat (5) @(negedge clk);
    chk("idle_hold_ready", s_ready, 0);
    chk("idle_hold_busy", busy, 0);

    chk("sb_empty", sb.size(), 0);
    chk("start_count", starts_seen, starts_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
